serial_cmd_rx: RTL and testbench

Serial command front end for `pulse_gen`. It receives 8N1 bytes on `RS232_Rx`, assembles fixed-length framed command packets, and verifies each packet's checksum. A valid packet becomes a one-cycle configuration write (`cfg_we`/`cfg_addr`/`cfg_data`) that `pulse_gen` latches into its timing registers. Each packet is answered with an ACK or NAK byte on `RS232_Tx`.

---
 rtl/serial_cmd_rx_pkg.sv | 39 +++
 rtl/serial_cmd_rx_uart.sv | 95 +++++++++
 rtl/serial_cmd_rx.sv | 164 ++++++++++++++++
 tb/tb_serial_cmd_rx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmd_rx_pkg.sv
// Shared constants and types for the pulse_gen serial command front end.
// Holds the protocol bytes, the error codes, the parser states and the config register map.
package pulse_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_FRAME   = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    PS_HUNT,
    PS_ADDR,
    PS_DATA,
    PS_CSUM
  } parse_state_e;

  typedef enum logic [2:0] {
    CFG_PERIOD     = 3'd0,
    CFG_P1_WIDTH   = 3'd1,
    CFG_P2_DELAY   = 3'd2,
    CFG_P2_WIDTH   = 3'd3,
    CFG_SYNC_DELAY = 3'd4,
    CFG_RSVD5      = 3'd5,
    CFG_RSVD6      = 3'd6,
    CFG_RSVD7      = 3'd7
  } cfg_addr_e;

  // Only the low three address bits map to registers; anything above is rejected.
  function automatic logic addr_ok(input logic [7:0] addr);
    return (addr[7:3] == 5'd0);
  endfunction

endpackage

// File: rtl/serial_cmd_rx_uart.sv
// 8N1 byte receiver: input synchronizer, start-bit validation and mid-bit sampling.
// Emits a one-cycle rx_valid with the byte, or rx_frame_err when the stop bit is low.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  rx_state_e     state;
  logic          sync1, sync2, rx_prev;
  logic [1:0]    settle;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      rx_prev      <= 1'b1;
      settle       <= 2'd0;
      state        <= RX_IDLE;
      bit_cnt      <= '0;
      bit_idx      <= 3'd0;
      shift        <= 8'd0;
      rx_valid     <= 1'b0;
      rx_byte      <= 8'd0;
      rx_frame_err <= 1'b0;
    end else begin
      sync1        <= rx;
      sync2        <= sync1;
      rx_prev      <= sync2;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      // The preset synchronizer looks like a falling edge if the line is low at reset release;
      // wait until real samples have reached rx_prev before edges are trusted.
      if (settle != 2'd3) settle <= settle + 2'd1;

      case (state)
        RX_IDLE: begin
          if (settle == 2'd3 && rx_prev && !sync2) begin
            state   <= RX_START;
            bit_cnt <= '0;
          end
        end
        RX_START: begin
          if (bit_cnt == HALF_CNT) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            state   <= sync2 ? RX_IDLE : RX_DATA;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (bit_cnt == FULL_CNT) begin
            bit_cnt <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (bit_cnt == FULL_CNT) begin
            bit_cnt <= '0;
            state   <= RX_IDLE;
            if (sync2) begin
              rx_valid <= 1'b1;
              rx_byte  <= shift;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_cmd_rx.sv
// Serial command front end for pulse_gen: packet parser with checksum and inter-byte timeout,
// config write strobe, and an ACK/NAK UART transmitter with a one-deep pending slot.
module serial_cmd_rx
  import pulse_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RS232_Rx,
  output logic        RS232_Tx,
  output logic        cfg_we,
  output logic [2:0]  cfg_addr,
  output logic [31:0] cfg_data,
  output logic        pkt_err,
  output logic [1:0]  err_code,
  output logic        tx_busy
);

  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);

  logic         rx_valid, rx_frame_err;
  logic [7:0]   rx_byte;

  parse_state_e state;
  logic [1:0]   data_idx;
  logic [7:0]   addr_q, csum_q;
  logic [31:0]  data_q;
  logic [TW-1:0] to_cnt;
  logic         resp_vld;
  logic [7:0]   resp_byte;

  logic [9:0]   tx_frame;
  logic [3:0]   tx_bit;
  logic [CW-1:0] tx_cnt;
  logic         pend_vld;
  logic [7:0]   pend_byte;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk          (clk),
    .reset        (reset),
    .rx           (RS232_Rx),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .rx_frame_err (rx_frame_err)
  );

  // Parser and timeout; an accepted byte takes priority over a timeout in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PS_HUNT;
      data_idx  <= 2'd0;
      addr_q    <= 8'd0;
      csum_q    <= 8'd0;
      data_q    <= 32'd0;
      to_cnt    <= '0;
      resp_vld  <= 1'b0;
      resp_byte <= 8'd0;
      cfg_we    <= 1'b0;
      cfg_addr  <= 3'd0;
      cfg_data  <= 32'd0;
      pkt_err   <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      cfg_we   <= 1'b0;
      pkt_err  <= 1'b0;
      resp_vld <= 1'b0;
      if (rx_frame_err) begin
        state    <= PS_HUNT;
        err_code <= ERR_FRAME;
        pkt_err  <= 1'b1;
        to_cnt   <= '0;
      end else if (rx_valid) begin
        to_cnt <= '0;
        case (state)
          PS_HUNT: if (rx_byte == SYNC_BYTE) state <= PS_ADDR;
          PS_ADDR: begin
            addr_q   <= rx_byte;
            csum_q   <= rx_byte;
            data_idx <= 2'd0;
            state    <= PS_DATA;
          end
          PS_DATA: begin
            data_q   <= {data_q[23:0], rx_byte};
            csum_q   <= csum_q ^ rx_byte;
            data_idx <= data_idx + 2'd1;
            if (data_idx == 2'd3) state <= PS_CSUM;
          end
          PS_CSUM: begin
            state    <= PS_HUNT;
            resp_vld <= 1'b1;
            if (rx_byte == csum_q && addr_ok(addr_q)) begin
              cfg_we    <= 1'b1;
              cfg_addr  <= addr_q[2:0];
              cfg_data  <= data_q;
              resp_byte <= ACK_BYTE;
            end else begin
              err_code  <= ERR_CSUM;
              pkt_err   <= 1'b1;
              resp_byte <= NAK_BYTE;
            end
          end
          default: state <= PS_HUNT;
        endcase
      end else if (state != PS_HUNT) begin
        if (to_cnt == TO_LAST) begin
          state    <= PS_HUNT;
          err_code <= ERR_TIMEOUT;
          pkt_err  <= 1'b1;
          to_cnt   <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  // Response transmitter; tx_frame shifts right so bit 1 is always the next line value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RS232_Tx  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_frame  <= 10'h3FF;
      tx_bit    <= 4'd0;
      tx_cnt    <= '0;
      pend_vld  <= 1'b0;
      pend_byte <= 8'd0;
    end else if (!tx_busy) begin
      if (resp_vld || pend_vld) begin
        RS232_Tx <= 1'b0;
        tx_busy  <= 1'b1;
        tx_frame <= {1'b1, (resp_vld ? resp_byte : pend_byte), 1'b0};
        tx_bit   <= 4'd0;
        tx_cnt   <= '0;
        pend_vld <= 1'b0;
      end
    end else begin
      if (resp_vld) begin
        pend_vld  <= 1'b1;
        pend_byte <= resp_byte;
      end
      if (tx_cnt == FULL_CNT) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy  <= 1'b0;
          RS232_Tx <= 1'b1;
        end else begin
          tx_bit   <= tx_bit + 4'd1;
          tx_frame <= {1'b1, tx_frame[9:1]};
          RS232_Tx <= tx_frame[1];
        end
      end else begin
        tx_cnt <= tx_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Directed bench for serial_cmd_rx: drives 8N1 packets, decodes the response line,
// and checks writes, errors and reset behaviour against hand-computed values.
module tb_serial_cmd_rx;

  localparam int CPB = 16;
  localparam int TO  = 2000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RS232_Rx = 1'b1;
  logic        RS232_Tx;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        pkt_err;
  logic [1:0]  err_code;
  logic        tx_busy;

  int total = 0;
  int bad   = 0;

  int          we_cnt  = 0;
  int          perr_cnt = 0;
  int          tx_cnt  = 0;
  logic [7:0]  tx_last = 8'h00;
  logic [2:0]  we_addr = 3'd0;
  logic [31:0] we_data = 32'd0;

  serial_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .RS232_Rx (RS232_Rx),
    .RS232_Tx (RS232_Tx),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .pkt_err  (pkt_err),
    .err_code (err_code),
    .tx_busy  (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (cfg_we) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= cfg_addr;
      we_data <= cfg_data;
    end
    if (pkt_err) perr_cnt <= perr_cnt + 1;
  end

  // Response line decoder, sampling mid-bit.
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge RS232_Tx);
      repeat (CPB / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        b[i] = RS232_Tx;
      end
      repeat (CPB) @(posedge clk);
      chk("tx_stop_bit", {31'd0, RS232_Tx}, 32'd1);
      tx_last = b;
      tx_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    RS232_Rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      RS232_Rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    RS232_Rx = stop_bit;
    repeat (CPB) @(posedge clk);
    RS232_Rx = 1'b1;
  endtask

  task automatic send_pkt(input logic [7:0] a, d3, d2, d1, d0, cs);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d3);
    send_byte(d2);
    send_byte(d1);
    send_byte(d0);
    send_byte(cs);
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_tx"},       {31'd0, RS232_Tx}, 32'd1);
    chk({pfx, "_cfg_we"},   {31'd0, cfg_we},   32'd0);
    chk({pfx, "_cfg_addr"}, {29'd0, cfg_addr}, 32'd0);
    chk({pfx, "_cfg_data"}, cfg_data,          32'd0);
    chk({pfx, "_pkt_err"},  {31'd0, pkt_err},  32'd0);
    chk({pfx, "_err_code"}, {30'd0, err_code}, 32'd0);
    chk({pfx, "_tx_busy"},  {31'd0, tx_busy},  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) @(posedge clk);
    #1 check_reset_vals("rst");
    reset = 1'b0;
    repeat (20) @(posedge clk);

    // Good packet: address 1, data 1000
    send_pkt(8'h01, 8'h00, 8'h00, 8'h03, 8'hE8, 8'hEA);
    repeat (12 * CPB) @(posedge clk);
    chk("good_we_cnt",  we_cnt,   32'd1);
    chk("good_addr",    {29'd0, we_addr}, 32'd1);
    chk("good_data",    we_data,  32'd1000);
    chk("good_hold",    cfg_data, 32'd1000);
    chk("good_tx_cnt",  tx_cnt,   32'd1);
    chk("good_tx_byte", {24'd0, tx_last}, 32'h06);
    chk("good_err",     {30'd0, err_code}, 32'd0);
    chk("good_perr",    perr_cnt, 32'd0);
    chk("good_busy",    {31'd0, tx_busy}, 32'd0);

    // Bad checksum
    send_pkt(8'h01, 8'h00, 8'h00, 8'h03, 8'hE8, 8'hEB);
    repeat (12 * CPB) @(posedge clk);
    chk("csum_we_cnt",  we_cnt,   32'd1);
    chk("csum_perr",    perr_cnt, 32'd1);
    chk("csum_err",     {30'd0, err_code}, 32'd2);
    chk("csum_tx_cnt",  tx_cnt,   32'd2);
    chk("csum_tx_byte", {24'd0, tx_last}, 32'h15);
    chk("csum_hold",    cfg_data, 32'd1000);

    // Out-of-range address with a correct checksum
    send_pkt(8'h08, 8'h00, 8'h00, 8'h03, 8'hE8, 8'hE3);
    repeat (12 * CPB) @(posedge clk);
    chk("addr_we_cnt",  we_cnt,   32'd1);
    chk("addr_perr",    perr_cnt, 32'd2);
    chk("addr_err",     {30'd0, err_code}, 32'd2);
    chk("addr_tx_cnt",  tx_cnt,   32'd3);
    chk("addr_tx_byte", {24'd0, tx_last}, 32'h15);

    // Framing error inside the data field
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03, 1'b0);
    repeat (12 * CPB) @(posedge clk);
    chk("frm_perr",   perr_cnt, 32'd3);
    chk("frm_err",    {30'd0, err_code}, 32'd1);
    chk("frm_tx_cnt", tx_cnt,   32'd3);
    chk("frm_we_cnt", we_cnt,   32'd1);
    send_pkt(8'h03, 8'h00, 8'h00, 8'h00, 8'h64, 8'h67);
    repeat (12 * CPB) @(posedge clk);
    chk("frm2_we_cnt",  we_cnt,  32'd2);
    chk("frm2_addr",    {29'd0, we_addr}, 32'd3);
    chk("frm2_data",    we_data, 32'd100);
    chk("frm2_tx_cnt",  tx_cnt,  32'd4);
    chk("frm2_tx_byte", {24'd0, tx_last}, 32'h06);
    chk("frm2_err",     {30'd0, err_code}, 32'd1);

    // Inter-byte timeout
    send_byte(8'hA5);
    send_byte(8'h02);
    repeat (TO + 10) @(posedge clk);
    chk("to_perr",   perr_cnt, 32'd4);
    chk("to_err",    {30'd0, err_code}, 32'd3);
    chk("to_tx_cnt", tx_cnt,   32'd4);
    chk("to_we_cnt", we_cnt,   32'd2);
    send_pkt(8'h01, 8'h00, 8'h00, 8'h03, 8'hE8, 8'hEA);
    repeat (12 * CPB) @(posedge clk);
    chk("to2_we_cnt",  we_cnt,  32'd3);
    chk("to2_addr",    {29'd0, we_addr}, 32'd1);
    chk("to2_data",    we_data, 32'd1000);
    chk("to2_tx_cnt",  tx_cnt,  32'd5);

    // Short low glitch on the idle line
    RS232_Rx = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    RS232_Rx = 1'b1;
    repeat (20 * CPB) @(posedge clk);
    chk("gl_we_cnt", we_cnt,   32'd3);
    chk("gl_perr",   perr_cnt, 32'd4);
    chk("gl_err",    {30'd0, err_code}, 32'd3);

    // Leading garbage before a good packet
    send_byte(8'h00);
    send_byte(8'hFF);
    send_pkt(8'h04, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h0E);
    repeat (12 * CPB) @(posedge clk);
    chk("gb_we_cnt",  we_cnt,  32'd4);
    chk("gb_addr",    {29'd0, we_addr}, 32'd4);
    chk("gb_data",    we_data, 32'd10);
    chk("gb_tx_cnt",  tx_cnt,  32'd6);
    chk("gb_perr",    perr_cnt, 32'd4);

    // Reset in the middle of D2
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h00);
    RS232_Rx = 1'b0;
    repeat (3 * CPB) @(posedge clk);
    #1 reset = 1'b1;
    #1 check_reset_vals("mid");
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (6 * CPB) @(posedge clk);
    RS232_Rx = 1'b1;
    repeat (CPB) @(posedge clk);
    send_byte(8'h00);
    send_byte(8'h07);
    send_byte(8'h02);
    repeat (12 * CPB) @(posedge clk);
    chk("mr_we_cnt", we_cnt, 32'd4);
    chk("mr_tx_cnt", tx_cnt, 32'd6);
    chk("mr_err",    {30'd0, err_code}, 32'd0);
    send_pkt(8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A);
    repeat (12 * CPB) @(posedge clk);
    chk("mr2_we_cnt",  we_cnt,  32'd5);
    chk("mr2_addr",    {29'd0, we_addr}, 32'd2);
    chk("mr2_data",    we_data, 32'h12345678);
    chk("mr2_tx_cnt",  tx_cnt,  32'd7);
    chk("mr2_tx_byte", {24'd0, tx_last}, 32'h06);
    chk("mr2_err",     {30'd0, err_code}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
